// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that shares one SerialTX byte transmitter between NUM_REQ requesters.
// Optional keep-grant behaviour is compiled in with `define SERIAL_ARB_LOCK_EN.
module serial_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   ack,
    output logic [2:0]           grant_id,
    output logic                 err_timeout,
    output logic                 tx_send,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

    state_t               state, state_next;
    logic [7:0]           cnt, cnt_next;
    logic [2:0]           last, last_next;
    logic [2:0]           grant_next;
    logic [7:0]           tx_data_next;
    logic                 tx_send_next;
    logic                 err_next;
    logic [NUM_REQ-1:0]   ack_next;

    logic [7:0]           req_pad;
    logic [63:0]          data_pad;
    logic [3:0]           sum;
    logic [2:0]           win;
    logic                 found;

`ifdef SERIAL_ARB_LOCK_EN
    logic                 lock_ok, lock_ok_next;
    logic [7:0]           lock_pad;
`else
    logic                 unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Winner search: first requester after `last`, wrapping modulo NUM_REQ.
    always_comb begin
        req_pad                 = '0;
        req_pad[NUM_REQ-1:0]    = req;
        data_pad                = '0;
        data_pad[8*NUM_REQ-1:0] = req_data;
        sum                     = '0;
        win                     = last;
        found                   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last} + 4'(k);
            if (sum >= 4'(NUM_REQ))
                sum = sum - 4'(NUM_REQ);
            if (!found && req_pad[sum[2:0]]) begin
                found = 1'b1;
                win   = sum[2:0];
            end
        end
`ifdef SERIAL_ARB_LOCK_EN
        lock_pad                = '0;
        lock_pad[NUM_REQ-1:0]   = req_lock;
        if (lock_ok && req_pad[last] && lock_pad[last]) begin
            found = 1'b1;
            win   = last;
        end
`endif
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        last_next    = last;
        grant_next   = grant_id;
        tx_data_next = tx_data;
        tx_send_next = 1'b0;
        ack_next     = '0;
        err_next     = 1'b0;
`ifdef SERIAL_ARB_LOCK_EN
        lock_ok_next = lock_ok;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_next   = ISSUE;
                    tx_data_next = data_pad[{win, 3'b000} +: 8];
                    grant_next   = win;
                    last_next    = win;
                    tx_send_next = 1'b1;
                    ack_next     = NUM_REQ'(8'd1 << win);
`ifdef SERIAL_ARB_LOCK_EN
                    lock_ok_next = 1'b0;
`endif
                end
            end
            ISSUE: begin
                cnt_next   = 8'(START_TIMEOUT);
                state_next = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt == 8'd1) begin
                    // Transmitter never started: report it and drop any lock.
                    err_next   = 1'b1;
                    cnt_next   = 8'd0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
`ifdef SERIAL_ARB_LOCK_EN
                    lock_ok_next = 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            last        <= 3'(NUM_REQ - 1);
            grant_id    <= 3'd0;
            tx_data     <= 8'h00;
            tx_send     <= 1'b0;
            ack         <= '0;
            err_timeout <= 1'b0;
`ifdef SERIAL_ARB_LOCK_EN
            lock_ok     <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            last        <= last_next;
            grant_id    <= grant_next;
            tx_data     <= tx_data_next;
            tx_send     <= tx_send_next;
            ack         <= ack_next;
            err_timeout <= err_next;
`ifdef SERIAL_ARB_LOCK_EN
            lock_ok     <= lock_ok_next;
`endif
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: SerialTX busy model, edge-timeline reference model,
// per-cycle output compare, directed scenarios and a randomized traffic phase.
module tb_serial_tx_arbiter;

    localparam int N = 4;
    localparam int T = 8;
`ifdef SERIAL_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   req_lock = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   ack;
    logic [2:0]     grant_id;
    logic           err_timeout;
    logic           tx_send;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;

    int checks = 0;
    int failures = 0;

    serial_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_lock(req_lock),
        .ack(ack), .grant_id(grant_id), .err_timeout(err_timeout),
        .tx_send(tx_send), .tx_data(tx_data), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // SerialTX stand-in: busy rises some cycles after an accepted send, then lasts a frame.
    bit stx_dead = 1'b0;
    bit stx_rand = 1'b0;
    int stx_pend = 0;
    int stx_left = 0;
    initial forever begin
        @(negedge clk);
        if (stx_left > 0) begin
            stx_left--;
            if (stx_left == 0) tx_busy = 1'b0;
        end else if (stx_pend > 0) begin
            stx_pend--;
            if (stx_pend == 0) begin
                tx_busy  = 1'b1;
                stx_left = stx_rand ? int'($urandom_range(1, 5)) : 4;
            end
        end
        if (tx_send === 1'b1 && !stx_dead && stx_pend == 0 && stx_left == 0)
            stx_pend = stx_rand ? (($urandom % 8 == 0) ? 12 : int'($urandom_range(1, 3))) : 2;
    end

    // Reference model: tracks edges since the last grant instead of controller states.
    logic [2:0]   m_last;
    bit           m_ready, m_seen, m_lock_ok;
    int           m_age;
    logic         exp_send, exp_err;
    logic [N-1:0] exp_ack;
    logic [7:0]   exp_data;
    logic [2:0]   exp_grant;

    function automatic int pick(input logic [N-1:0] r, input logic [N-1:0] lk,
                                input int last, input bit lock_ok);
        if (LOCK_EN && lock_ok && r[last] && lk[last]) return last;
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return last;
    endfunction

    function automatic void m_reset();
        m_last = 3'(N - 1); m_ready = 1'b1; m_seen = 1'b0; m_lock_ok = 1'b0; m_age = 0;
        exp_send = 1'b0; exp_err = 1'b0; exp_ack = '0; exp_data = 8'h00; exp_grant = 3'd0;
    endfunction

    function automatic void m_step();
        int w;
        exp_send = 1'b0; exp_err = 1'b0; exp_ack = '0;
        if (m_ready) begin
            if (req != '0) begin
                w = pick(req, req_lock, int'(m_last), m_lock_ok);
                m_last = 3'(w); exp_grant = 3'(w); exp_data = req_data[8*w +: 8];
                exp_send = 1'b1; exp_ack = N'(1) << w;
                m_ready = 1'b0; m_age = 0; m_seen = 1'b0; m_lock_ok = 1'b0;
            end
        end else begin
            m_age++;
            if (m_age >= 2) begin
                if (!m_seen) begin
                    if (tx_busy) m_seen = 1'b1;
                    else if (m_age == T + 1) begin
                        exp_err = 1'b1; m_ready = 1'b1; m_lock_ok = 1'b0;
                    end
                end else if (!tx_busy) begin
                    m_ready = 1'b1; m_lock_ok = 1'b1;
                end
            end
        end
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            chk("cyc_tx_send", 32'(tx_send), 32'(exp_send));
            chk("cyc_ack", 32'(ack), 32'(exp_ack));
            chk("cyc_err_timeout", 32'(err_timeout), 32'(exp_err));
            chk("cyc_tx_data", 32'(tx_data), 32'(exp_data));
            chk("cyc_grant_id", 32'(grant_id), 32'(exp_grant));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_send(input string name, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx_send === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL %s no tx_send within 200 cycles", name);
        end
    endtask

    task automatic count_to_err(input string name);
        int k;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) begin k = c; break; end
        end
        chk(name, 32'(k), 32'(T + 1));
    endtask

    task automatic do_reset();
        req = '0; req_lock = '0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic rand_step();
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                if ($urandom % 2 == 1) req_data[8*i +: 8] = 8'($urandom);
                else req[i] = 1'b0;
            end else if (!req[i]) begin
                if ($urandom % 4 == 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_lock[i] = 1'($urandom % 2);
                end
            end else if ($urandom % 64 == 0) begin
                req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        bit ok;
        int k;
        int n1;
        int acks [N];
        logic [2:0] g [4];
        int exp_g [4];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_send", 32'(tx_send), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_err", 32'(err_timeout), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte, latency and gap to the next grant
        req_data[7:0] = 8'hDE; req[0] = 1'b1;
        @(negedge clk);
        chk("single_latency_send", 32'(tx_send), 32'h1);
        chk("single_data", 32'(tx_data), 32'hDE);
        chk("single_ack", 32'(ack), 32'h1);
        chk("single_grant", 32'(grant_id), 32'h0);
        req[0] = 1'b0; req_data[15:8] = 8'h21; req[1] = 1'b1;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (tx_send === 1'b1) begin k = c; break; end
        end
        chk("single_gap", 32'(k), 32'd8);
        chk("single_second_data", 32'(tx_data), 32'h21);
        chk("single_second_ack", 32'(ack), 32'h2);
        req[1] = 1'b0;

        // Timeout with a silent transmitter
        do_reset();
        stx_dead = 1'b1;
        req_data[23:16] = 8'hC2; req[2] = 1'b1;
        wait_send("timeout_first", ok);
        chk("timeout_first_grant", 32'(grant_id), 32'd2);
        req_data[31:24] = 8'hC3; req[3] = 1'b1;
        count_to_err("timeout_delay_a");
        wait_send("timeout_second", ok);
        chk("timeout_next_grant_3", 32'(grant_id), 32'd3);
        chk("timeout_next_data", 32'(tx_data), 32'hC3);
        req[3] = 1'b0;
        count_to_err("timeout_delay_b");
        wait_send("timeout_third", ok);
        chk("timeout_regrant_2", 32'(grant_id), 32'd2);
        req[2] = 1'b0;
        repeat (20) @(negedge clk);
        stx_dead = 1'b0;

        // Fairness with all requesters held
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_data[8*i +: 8] = 8'(8'h10 + i);
            acks[i] = 0;
        end
        req = '1;
        for (int j = 0; j < 8; j++) begin
            wait_send("fair_send", ok);
            chk("fair_order", 32'(tx_data), 32'(8'h10 + (j % 4)));
            for (int i = 0; i < N; i++) if (ack[i]) acks[i]++;
        end
        req = '0;
        for (int i = 0; i < N; i++) chk("fair_acks_per_req", 32'(acks[i]), 32'd2);

        // Reset asserted while the frame is in flight
        do_reset();
        req_data[23:16] = 8'h5A; req[2] = 1'b1;
        wait_send("midrst_send", ok);
        req[2] = 1'b0;
        chk("midrst_grant_before", 32'(grant_id), 32'd2);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx_data", 32'(tx_data), 32'h0);
        chk("midrst_grant_id", 32'(grant_id), 32'h0);
        chk("midrst_tx_send", 32'(tx_send), 32'h0);
        chk("midrst_ack", 32'(ack), 32'h0);
        chk("midrst_err", 32'(err_timeout), 32'h0);
        req_data[7:0] = 8'h77; req[0] = 1'b1; req[2] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_send("midrst_after", ok);
        chk("midrst_first_winner", 32'(grant_id), 32'd0);
        chk("midrst_first_data", 32'(tx_data), 32'h77);
        req[0] = 1'b0;
        wait_send("midrst_then", ok);
        chk("midrst_second_winner", 32'(grant_id), 32'd2);
        req[2] = 1'b0;

        // Keep-grant for a multi-byte message
        do_reset();
        req_data[7:0] = 8'h01; req[0] = 1'b1;
        wait_send("lock_setup", ok);
        req[0] = 1'b0;
        repeat (20) @(negedge clk);
        req_data[15:8] = 8'hB0; req[1] = 1'b1; req_lock[1] = 1'b1; req[0] = 1'b1;
        n1 = 0;
        for (int j = 0; j < 4; j++) begin
            wait_send("lock_send", ok);
            g[j] = grant_id;
            if (ack[1]) begin
                n1++;
                req_data[15:8] = 8'(8'hB0 + n1);
                if (n1 == 3) begin req[1] = 1'b0; req_lock[1] = 1'b0; end
            end
        end
        req = '0; req_lock = '0;
        if (LOCK_EN) exp_g = '{1, 1, 1, 0};
        else exp_g = '{1, 0, 1, 0};
        for (int j = 0; j < 4; j++) chk("lock_grant_order", 32'(g[j]), 32'(exp_g[j]));

        // Randomized traffic against the reference model
        do_reset();
        stx_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rand_step();
        end
        req = '0; req_lock = '0;
        stx_rand = 1'b0;
        repeat (60) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
